// File: rtl/mul_stream_ctrl.sv
// mul_stream_ctrl: sequences one signed 16x16 multiply at a time through an
// external multiplier and queues the 32-bit products in a small result FIFO.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready          operand handshake, in_a/in_b signed 16-bit operands
//   mul_start                  one-cycle start pulse to the multiplier
//   mul_a/mul_b                registered operands held for the multiplier
//   mul_product/mul_done       multiplier result and its one-cycle valid pulse
//   out_valid/out_ready        result stream handshake, out_product = FIFO head
//   busy                       operation in progress or results still queued
//   timeout_err/clear_err      sticky missing-done flag and its synchronous clear
module mul_stream_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_a,
  input  logic signed [15:0] in_b,
  output logic               mul_start,
  output logic signed [15:0] mul_a,
  output logic signed [15:0] mul_b,
  input  logic signed [31:0] mul_product,
  input  logic               mul_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] out_product,
  output logic               busy,
  output logic               timeout_err,
  input  logic               clear_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic signed [15:0] mul_a_q, mul_b_q;
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic signed [31:0] mem_q [DEPTH];
  logic               err_q, err_d;
  logic               accept, push, pop, timeout_hit;

  // Only one operation is ever in flight, so checking for a free slot at
  // accept time is enough to make FIFO overflow impossible.
  assign in_ready    = (state_q == StIdle) && (count_q < CntW'(DEPTH));
  assign accept      = in_valid && in_ready;
  assign out_valid   = (count_q != '0);
  assign pop         = out_valid && out_ready;
  assign out_product = mem_q[rd_ptr_q];
  assign mul_start   = (state_q == StIssue);
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign busy        = (state_q != StIdle) || out_valid;
  assign timeout_err = err_q;

  // mul_done outside StWait falls through untouched: no push, no transition.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    push        = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) state_d = StIssue;
      end
      StIssue: begin
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        if (mul_done) begin
          push    = 1'b1;
          state_d = StIdle;
        end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
          // TIMEOUT cycles spent in StWait without a done pulse
          timeout_hit = 1'b1;
          state_d     = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // A new timeout wins over a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (clear_err)   err_d = 1'b0;
    if (timeout_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      count_q    <= count_d;
      err_q      <= err_d;
      if (accept) begin
        mul_a_q <= in_a;
        mul_b_q <= in_b;
      end
      // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage is reset so out_product reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= mul_product;
    end
  end

endmodule

// File: tb/tb_mul_stream_ctrl.sv
// tb_mul_stream_ctrl: self-checking bench for mul_stream_ctrl with a behavioural
// multiplier model and a product scoreboard fed from the operand handshake.
module tb_mul_stream_ctrl;

  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned DEPTH   = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               in_valid, in_ready;
  logic signed [15:0] in_a, in_b;
  logic               mul_start;
  logic signed [15:0] mul_a, mul_b;
  logic signed [31:0] mul_product;
  logic               mul_done;
  logic               out_valid, out_ready;
  logic signed [31:0] out_product;
  logic               busy, timeout_err, clear_err;

  int tests = 0;
  int errors = 0;
  int cyc = 0;
  int n_pop = 0;
  bit acc;
  bit mul_en = 1'b1;
  bit rand_lat = 1'b0;
  bit spurious = 1'b0;
  int lat_left;
  logic signed [31:0] exp_q [$];

  mul_stream_ctrl #(
    .TIMEOUT(TIMEOUT),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_product(mul_product),
    .mul_done   (mul_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_product(out_product),
    .busy       (busy),
    .timeout_err(timeout_err),
    .clear_err  (clear_err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  function automatic logic signed [31:0] ref_mul(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
    logic signed [31:0] wa, wb;
    wa = a;
    wb = b;
    return wa * wb;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Records the handshakes that the coming rising edge will take, then moves to
  // the next falling edge where outputs are stable for checking and driving.
  task automatic next_cycle();
    acc = in_valid && in_ready && rst_n;
    if (acc) exp_q.push_back(ref_mul(in_a, in_b));
    if (out_valid && out_ready && rst_n) begin
      n_pop++;
      check("sb_nonempty_on_pop", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) check("sb_product", out_product, exp_q.pop_front());
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic signed [15:0] a, input logic signed [15:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    for (int i = 0; i < 50; i++) begin
      next_cycle();
      if (acc) break;
    end
    check("send_accepted", {31'b0, acc}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      next_cycle();
      seen = out_valid;
    end
    check(tag, {31'b0, seen}, 32'd1);
  endtask

  // Multiplier model: done pulse a fixed or random number of cycles after start.
  initial begin
    mul_done    = 1'b0;
    mul_product = '0;
    lat_left    = 0;
    forever begin
      @(negedge clk);
      mul_done = 1'b0;
      if (lat_left > 0) begin
        lat_left--;
        if (lat_left == 0) begin
          mul_done    = 1'b1;
          mul_product = ref_mul(mul_a, mul_b);
        end
      end
      if (spurious) begin
        mul_done    = 1'b1;
        mul_product = 32'h1234_5678;
      end
      if (mul_start && mul_en) lat_left = rand_lat ? int'($urandom_range(1, 5)) : 2;
    end
  end

  initial begin
    int t0, t1, n_acc, c, pop0, bp_acc;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    clear_err = 1'b0;
    #1 rst_n = 1'b0;

    // Reset state
    next_cycle();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_product", out_product, 32'd0);
    check("rst_mul_start", {31'b0, mul_start}, 32'd0);
    check("rst_mul_a", {16'b0, mul_a}, 32'd0);
    check("rst_mul_b", {16'b0, mul_b}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    next_cycle();

    // Single operation with exact latency; accept edge closes cycle N
    out_ready = 1'b1;
    send(16'sd3, -16'sd7);  // now in N+1
    check("op_mul_start", {31'b0, mul_start}, 32'd1);
    check("op_mul_a", {16'b0, mul_a}, 32'h0000_0003);
    check("op_mul_b", {16'b0, mul_b}, 32'h0000_fff9);
    check("op_in_ready_busy", {31'b0, in_ready}, 32'd0);
    check("op_busy", {31'b0, busy}, 32'd1);
    next_cycle();  // N+2
    check("op_start_pulse", {31'b0, mul_start}, 32'd0);
    next_cycle();  // N+3
    check("op_no_early_valid", {31'b0, out_valid}, 32'd0);
    next_cycle();  // N+4
    check("op_valid_n4", {31'b0, out_valid}, 32'd1);
    check("op_product", out_product, 32'hffff_ffeb);
    next_cycle();  // N+5
    check("op_valid_one_cycle", {31'b0, out_valid}, 32'd0);
    check("op_idle_busy", {31'b0, busy}, 32'd0);

    // Corner products, back-to-back throughput, hold under backpressure
    out_ready = 1'b0;
    send(16'sh8000, 16'sh8000);
    t0 = cyc;
    send(16'sh7fff, 16'sh8000);
    t1 = cyc;
    check("throughput_4", 32'(t1 - t0), 32'd4);
    check("corner1_valid", {31'b0, out_valid}, 32'd1);
    check("corner1_product", out_product, 32'h4000_0000);
    out_ready = 1'b1;
    next_cycle();
    wait_out("corner2_valid");
    check("corner2_product", out_product, 32'hc000_8000);
    next_cycle();

    // Backpressure: two results fill the FIFO, third pair must wait
    out_ready = 1'b0;
    send(16'sd100, 16'sd200);
    send(-16'sd5, 16'sd9);
    in_valid = 1'b1;
    in_a     = 16'sd1234;
    in_b     = -16'sd2;
    bp_acc   = 0;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      if (acc) bp_acc++;
    end
    check("bp_no_third_accept", 32'(bp_acc), 32'd0);
    check("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
    check("bp_head_held", out_product, 32'd20000);
    out_ready = 1'b1;
    send(16'sd1234, -16'sd2);
    for (int i = 0; i < 30 && (exp_q.size() != 0 || out_valid); i++) next_cycle();
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Timeout: multiplier stays silent
    mul_en = 1'b0;
    send(16'sd7, 16'sd7);  // N+1
    for (int i = 0; i < int'(TIMEOUT); i++) next_cycle();  // N+1+TIMEOUT
    check("to_not_early", {31'b0, timeout_err}, 32'd0);
    check("to_wait_in_ready", {31'b0, in_ready}, 32'd0);
    next_cycle();  // N+2+TIMEOUT
    check("to_err_set", {31'b0, timeout_err}, 32'd1);
    check("to_in_ready", {31'b0, in_ready}, 32'd1);
    check("to_no_push", {31'b0, out_valid}, 32'd0);
    exp_q.delete();  // the timed-out pair produces nothing
    next_cycle();
    next_cycle();
    check("to_sticky", {31'b0, timeout_err}, 32'd1);
    clear_err = 1'b1;
    next_cycle();
    check("to_cleared", {31'b0, timeout_err}, 32'd0);

    // Timeout coinciding with a held clear: set wins, clear applies after
    send(16'sd2, 16'sd2);
    for (int i = 0; i < int'(TIMEOUT) + 1; i++) next_cycle();
    check("to_set_beats_clear", {31'b0, timeout_err}, 32'd1);
    exp_q.delete();
    next_cycle();
    check("to_clear_after", {31'b0, timeout_err}, 32'd0);
    clear_err = 1'b0;
    mul_en    = 1'b1;

    // Reset during WAIT; late done must be ignored
    out_ready = 1'b1;
    send(16'sd5, 16'sd6);  // N+1
    next_cycle();          // N+2
    rst_n = 1'b0;
    #1;
    check("wrst_mul_start", {31'b0, mul_start}, 32'd0);
    check("wrst_mul_a", {16'b0, mul_a}, 32'd0);
    check("wrst_mul_b", {16'b0, mul_b}, 32'd0);
    check("wrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("wrst_out_product", out_product, 32'd0);
    check("wrst_busy", {31'b0, busy}, 32'd0);
    check("wrst_timeout_err", {31'b0, timeout_err}, 32'd0);
    exp_q.delete();
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    spurious = 1'b1;
    next_cycle();
    spurious = 1'b0;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      check("wrst_late_done_ignored", {31'b0, out_valid}, 32'd0);
    end
    check("wrst_idle", {31'b0, busy}, 32'd0);

    // Random stream with random latency and backpressure
    rand_lat = 1'b1;
    pop0     = n_pop;
    n_acc    = 0;
    c        = 0;
    while (c < 30000 && n_acc < 1000) begin
      next_cycle();
      c++;
      if (acc) n_acc++;
      if (acc || !in_valid) begin
        if (n_acc < 1000 && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          in_a     = 16'($urandom);
          in_b     = 16'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || out_valid); i++) next_cycle();
    check("rnd_all_accepted", 32'(n_acc), 32'd1000);
    check("rnd_all_popped", 32'(n_pop - pop0), 32'd1000);
    check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
    check("rnd_no_timeout", {31'b0, timeout_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/mul_stream_ctrl.md
MUL_STREAM_CTRL -- requirements
Module: mul_stream_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: max cycles waiting for mul_done after mul_start, range 4..255.
REQ-002 SHALL have parameter DEPTH, default 2: result FIFO entries, power of two, 2..8.
REQ-003 SHALL have port clk, input, 1: clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: operand pair valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts operand pair.
REQ-007 SHALL have ports in_a and in_b, input, 16 each, signed operands.
REQ-008 SHALL have port mul_start, output, 1: one-cycle start pulse to the multiplier.
REQ-009 SHALL have ports mul_a and mul_b, output, 16 each, signed operands to the multiplier, registered.
REQ-010 SHALL have port mul_product, input, 32, signed multiplier result.
REQ-011 SHALL have port mul_done, input, 1: multiplier result valid, one-cycle pulse.
REQ-012 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_product (output, 32, signed): result stream.
REQ-013 SHALL have port busy, output, 1: high when state is not IDLE or the FIFO is non-empty.
REQ-014 SHALL have ports timeout_err (output, 1, sticky) and clear_err (input, 1, synchronous clear).

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE and WAIT.
REQ-016 in_ready SHALL equal (state==IDLE) AND (fifo_count < DEPTH), combinationally.
REQ-017 IDLE: on in_valid AND in_ready, SHALL latch in_a/in_b into mul_a/mul_b and go to ISSUE; otherwise stay in IDLE.
REQ-018 ISSUE: SHALL assert mul_start for exactly this one cycle, clear the wait counter, then go to WAIT.
REQ-019 mul_a/mul_b SHALL stay stable from ISSUE until the next accept.
REQ-020 WAIT: on mul_done, SHALL push mul_product into the FIFO and go to IDLE.
REQ-021 WAIT: the counter SHALL increment each cycle without mul_done; when it reaches TIMEOUT, SHALL set timeout_err, push nothing and go to IDLE.
REQ-022 mul_done in any state other than WAIT SHALL be ignored: no push and no state change.
REQ-023 With a multiplier that asserts done two cycles after start, an accept at cycle N SHALL give mul_start at N+1, done at N+3, and out_valid at N+4 if the FIFO was empty.
REQ-024 Sustained throughput SHALL be one product per 4 cycles.
REQ-025 The FIFO SHALL be first-in first-out, with out_product driven from the head entry and out_valid = (fifo_count != 0).
REQ-026 A pop occurs on out_valid AND out_ready; a push and a pop in the same cycle SHALL leave fifo_count unchanged and preserve order.
REQ-027 FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-028 Overflow SHALL be impossible: accept requires fifo_count < DEPTH, and at most one operation is in flight.
REQ-029 out_product and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 clear_err SHALL clear timeout_err next cycle; if clear_err and a new timeout coincide, timeout_err SHALL be set.
REQ-031 Products SHALL pass through unmodified: 32-bit signed, no truncation or saturation.

Reset
REQ-032 rst_n low SHALL immediately set state IDLE, counter 0, fifo_count 0, pointers 0, mul_start 0, mul_a/mul_b 0, out_valid 0, out_product 0, timeout_err 0 and busy 0.
REQ-033 Reset during WAIT SHALL abandon the operation; a later mul_done SHALL be ignored per REQ-022.

Verification
REQ-034 Single op: a=3, b=-7, out_ready=1 -> out_product=-21, out_valid for 1 cycle at N+4.
REQ-035 Corner: a=-32768, b=-32768 -> out_product=1073741824; a=32767, b=-32768 -> -1073709056.
REQ-036 Backpressure: out_ready=0 with 3 pairs offered -> 2 accepted, in_ready=0 while FIFO full; raise out_ready -> results drain in order, third pair then accepted.
REQ-037 Timeout: model never asserts mul_done -> timeout_err=1 exactly TIMEOUT cycles after entering WAIT, no push, in_ready=1 next cycle; clear_err -> timeout_err=0.
REQ-038 Reset: rst_n low one cycle after mul_start -> all outputs 0; late mul_done -> out_valid stays 0.
REQ-039 Random stream: 1000 random pairs with random in_valid/out_ready -> all products match a*b in order, no loss or duplication.
